// File: rtl/sample_streamer_if.sv
// sample_streamer_if: host-side write/start bus and filter-side stream outputs.
// sent_cnt exists only when STREAMER_SAMPLE_CNT_EN is defined.
interface sample_streamer_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        start;
  logic [7:0]  interval;
  logic [31:0] data_out;
  logic        e_out;
  logic        full;
  logic        empty;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef STREAMER_SAMPLE_CNT_EN
  logic [15:0] sent_cnt;

  modport master (
    output wr_en, wr_data, start, interval,
    input  data_out, e_out, full, empty,
    input  busy, done, overflow, sent_cnt
  );

  modport slave (
    input  wr_en, wr_data, start, interval,
    output data_out, e_out, full, empty,
    output busy, done, overflow, sent_cnt
  );
`else
  modport master (
    output wr_en, wr_data, start, interval,
    input  data_out, e_out, full, empty,
    input  busy, done, overflow
  );

  modport slave (
    input  wr_en, wr_data, start, interval,
    output data_out, e_out, full, empty,
    output busy, done, overflow
  );
`endif
endinterface

// File: rtl/sample_streamer.sv
// sample_streamer: 16x32 FIFO feeding a filter one word every interval+1 cycles.
// Optional sent_cnt pulse counter under macro STREAMER_SAMPLE_CNT_EN.
module sample_streamer (
  input logic clk,
  input logic nRST,
  sample_streamer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] mem [16];
  logic [3:0]  wptr;
  logic [3:0]  rptr;
  logic [4:0]  count;
  logic [7:0]  ival;
  logic [7:0]  gap;
  logic [31:0] data_q;
  logic        e_q;
  logic        ovf_q;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        launch;

  assign full  = (count == 5'd16);
  assign empty = (count == 5'd0);
  assign push  = bus.wr_en && !full;

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode; emptiness is judged on the registered occupancy
  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !empty) begin
          state_nx = RUN;
          launch   = 1'b1;
        end
      end
      RUN: begin
        if (gap == 8'd0) begin
          if (!empty) pop = 1'b1;
          else        state_nx = DRAIN;
        end
      end
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sample storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wptr  <= 4'd0;
      rptr  <= 4'd0;
      count <= 5'd0;
    end else begin
      if (push) wptr <= wptr + 4'd1;
      if (pop)  rptr <= rptr + 4'd1;
      if (push && !pop)      count <= count + 5'd1;
      else if (!push && pop) count <= count - 5'd1;
    end
  end

  // Interval latch and inter-sample gap counter
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ival <= 8'd0;
      gap  <= 8'd0;
    end else if (launch) begin
      ival <= bus.interval;
      gap  <= 8'd0;
    end else if (state == RUN) begin
      if (gap != 8'd0) gap <= gap - 8'd1;
      else if (pop)    gap <= ival;
    end
  end

  // Output sample register and its one-cycle strobe
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      data_q <= 32'd0;
      e_q    <= 1'b0;
    end else begin
      e_q <= pop;
      if (pop) data_q <= mem[rptr];
    end
  end

  // Sticky overflow: any write attempt while full, even alongside a pop
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)                  ovf_q <= 1'b0;
    else if (bus.wr_en && full) ovf_q <= 1'b1;
  end

`ifdef STREAMER_SAMPLE_CNT_EN
  logic [15:0] cnt_q;

  // Pulses sent in the current stream; restarts on each launch
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)       cnt_q <= 16'd0;
    else if (launch) cnt_q <= 16'd0;
    else if (pop)    cnt_q <= cnt_q + 16'd1;
  end

  assign bus.sent_cnt = cnt_q;
`endif

  assign bus.data_out = data_q;
  assign bus.e_out    = e_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DRAIN);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_sample_streamer.sv
// tb_sample_streamer: directed scenario tasks for sample_streamer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sample_streamer;

  logic clk;
  logic nRST;
  int   n_checks;
  int   n_pass;

  sample_streamer_if bus ();

  sample_streamer dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic write_word(input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] iv);
    bus.interval = iv;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic test_reset();
    logic [38:0] got;
    logic [38:0] exp;
    nRST = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got = {bus.data_out, bus.e_out, bus.full, bus.empty,
           bus.busy, bus.done, bus.overflow};
    exp = {32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (got !== exp)
      $display("FAIL reset_outputs got %h exp %h", got, exp);
    else n_pass++;
    nRST = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] w [3];
    w[0] = 32'd10;
    w[1] = 32'd20;
    w[2] = 32'd30;
    for (int i = 0; i < 3; i++) write_word(w[i]);
    do_start(8'd0);
    n_checks++;
    if ({bus.busy, bus.e_out} !== 2'b10)
      $display("FAIL basic_after_start busy,e %b exp 10",
               {bus.busy, bus.e_out});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.e_out !== 1'b1 || bus.data_out !== w[i])
        $display("FAIL basic_pulse%0d e=%b d=%0d exp e=1 d=%0d",
                 i, bus.e_out, bus.data_out, w[i]);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.e_out} !== 2'b10)
      $display("FAIL basic_done done,e %b exp 10",
               {bus.done, bus.e_out});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.busy, bus.empty} !== 3'b001)
      $display("FAIL basic_idle done,busy,empty %b exp 001",
               {bus.done, bus.busy, bus.empty});
    else n_pass++;
  endtask

  task automatic test_interval();
    logic [31:0] w [3];
    logic [34:0] got;
    logic [34:0] exp;
    logic [31:0] ed;
    logic        ee;
    w[0] = 32'h111;
    w[1] = 32'h222;
    w[2] = 32'h333;
    for (int i = 0; i < 3; i++) write_word(w[i]);
    bus.interval = 8'd2;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.interval = 8'd0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      ee = (c == 1) || (c == 4) || (c == 7);
      ed = (c < 4) ? w[0] : (c < 7) ? w[1] : w[2];
      got = {bus.e_out, bus.done, bus.busy, bus.data_out};
      exp = {ee, (c == 10), (c < 10), ed};
      n_checks++;
      if (got !== exp)
        $display("FAIL interval_c%0d e,done,busy,d %h exp %h",
                 c, got, exp);
      else n_pass++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) write_word(32'h1000 + i);
    n_checks++;
    if ({bus.full, bus.overflow} !== 2'b10)
      $display("FAIL ovf_full16 full,ovf %b exp 10",
               {bus.full, bus.overflow});
    else n_pass++;
    write_word(32'hDEAD);
    n_checks++;
    if ({bus.full, bus.overflow} !== 2'b11)
      $display("FAIL ovf_write17 full,ovf %b exp 11",
               {bus.full, bus.overflow});
    else n_pass++;
    do_start(8'd0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'hBAD;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      n_checks++;
      if (c <= 16) begin
        if (bus.e_out !== 1'b1 || bus.data_out !== 32'h1000 + c - 1)
          $display("FAIL ovf_word%0d e=%b d=%h exp e=1 d=%h",
                   c, bus.e_out, bus.data_out, 32'h1000 + c - 1);
        else n_pass++;
      end else begin
        if ({bus.e_out, bus.done, bus.overflow} !== 3'b011)
          $display("FAIL ovf_end e,done,ovf %b exp 011",
                   {bus.e_out, bus.done, bus.overflow});
        else n_pass++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_extend();
    logic [33:0] got;
    logic [33:0] exp;
    logic [31:0] ed;
    logic        ee;
    write_word(32'hA);
    write_word(32'hB);
    do_start(8'd3);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 2) bus.wr_en = 1'b0;
      ee = (c == 1) || (c == 5) || (c == 9);
      ed = (c < 5) ? 32'hA : (c < 9) ? 32'hB : 32'hC;
      got = {bus.e_out, bus.done, bus.data_out};
      exp = {ee, (c == 13), ed};
      n_checks++;
      if (got !== exp)
        $display("FAIL extend_c%0d e,done,d %h exp %h", c, got, exp);
      else n_pass++;
      if (c == 1) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'hC;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [38:0] got;
    logic [38:0] exp;
    for (int i = 0; i < 5; i++) write_word(32'h50 + i);
    do_start(8'd0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.e_out !== 1'b1 || bus.data_out !== 32'h50 + c - 1)
        $display("FAIL rstmid_pre%0d e=%b d=%h exp e=1 d=%h",
                 c, bus.e_out, bus.data_out, 32'h50 + c - 1);
      else n_pass++;
    end
    nRST = 1'b0;
    #1;
    got = {bus.data_out, bus.e_out, bus.full, bus.empty,
           bus.busy, bus.done, bus.overflow};
    exp = {32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (got !== exp)
      $display("FAIL rstmid_async got %h exp %h", got, exp);
    else n_pass++;
    @(negedge clk);
    nRST = 1'b1;
    bus.interval = 8'd0;
    bus.start    = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.e_out, bus.busy, bus.empty} !== 3'b001)
        $display("FAIL rstmid_idle%0d e,busy,empty %b exp 001",
                 c, {bus.e_out, bus.busy, bus.empty});
      else n_pass++;
    end
    bus.start = 1'b0;
    write_word(32'h77);
    do_start(8'd0);
    @(negedge clk);
    n_checks++;
    if (bus.e_out !== 1'b1 || bus.data_out !== 32'h77)
      $display("FAIL rstmid_restart e=%b d=%h exp e=1 d=77",
               bus.e_out, bus.data_out);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
  endtask

`ifdef STREAMER_SAMPLE_CNT_EN
  task automatic test_sent_cnt();
    for (int i = 0; i < 5; i++) write_word(32'h90 + i);
    do_start(8'd0);
    repeat (7) @(negedge clk);
    n_checks++;
    if (bus.sent_cnt !== 16'd5)
      $display("FAIL cnt_five got %0d exp 5", bus.sent_cnt);
    else n_pass++;
    write_word(32'h1);
    write_word(32'h2);
    do_start(8'd0);
    n_checks++;
    if (bus.sent_cnt !== 16'd0)
      $display("FAIL cnt_clear got %0d exp 0", bus.sent_cnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.sent_cnt !== 16'd1)
      $display("FAIL cnt_restart got %0d exp 1", bus.sent_cnt);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    nRST         = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = 32'd0;
    bus.start    = 1'b0;
    bus.interval = 8'd0;
    test_reset();
    test_basic();
    test_interval();
    test_overflow();
    test_extend();
    test_reset_mid();
`ifdef STREAMER_SAMPLE_CNT_EN
    test_sent_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
